// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared FSM state encodings and operation codes for serial_addsub
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple adder slice
//
// Ports:
//   x, y   in  [DIGIT-1:0]  operand digits
//   cin    in  1            carry into the slice LSB
//   sum    out [DIGIT-1:0]  sum digit
//   cout   out 1            carry out of the slice MSB
//   c_msb  out 1            carry into the slice MSB (overflow detection on the top digit)
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor, LSB digit first, one-cycle done pulse
//
// Ports:
//   clk    in  1        rising-edge clock
//   rst    in  1        asynchronous active-high reset
//   start  in  1        request, sampled in IDLE or DONE
//   a, b   in  WIDTH    operands, captured on accept
//   sel    in  1        0 = a+b, 1 = a-b, captured on accept
//   busy   out 1        high while digits are processed (N cycles)
//   done   out 1        single-cycle result-valid pulse
//   s      out WIDTH    result mod 2^WIDTH
//   cout   out 1        carry out of MSB (subtract: 1 = no borrow)
//   ovf    out 1        two's-complement overflow
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_params
            $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_cmsb;
    // Result digit enters at the top; concatenation keeps this legal when DIGIT == WIDTH.
    logic [WIDTH+DIGIT-1:0] acc_wide;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (a_sh_q[DIGIT-1:0]),
        .y     (b_sh_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    assign acc_wide = {dig_sum, acc_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    // Subtract as a + ~b + 1: invert b once here, seed carry with sel.
                    a_sh_d  = a;
                    b_sh_d  = b ^ {WIDTH{sel == OP_SUB}};
                    carry_d = (sel == OP_SUB);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                acc_d   = acc_wide[WIDTH+DIGIT-1:DIGIT];
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    s_d     = acc_wide[WIDTH+DIGIT-1:DIGIT];
                    cout_d  = dig_cout;
                    ovf_d   = dig_cout ^ dig_cmsb;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (4x1 and 8x4 instances)
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       sel   = 1'b0;
    logic       use8  = 1'b0;
    logic [7:0] a     = '0;
    logic [7:0] b     = '0;

    logic       start4, start8;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] s4;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    logic       obusy, odone, ocout, oovf;
    logic [7:0] os;

    int total = 0;
    int bad   = 0;
    int last_s [2];
    int last_c [2];
    int last_o [2];

    always #5 clk = ~clk;

    assign start4 = start & ~use8;
    assign start8 = start & use8;

    assign obusy = use8 ? busy8 : busy4;
    assign odone = use8 ? done8 : done4;
    assign os    = use8 ? s8    : {4'b0, s4};
    assign ocout = use8 ? cout8 : cout4;
    assign oovf  = use8 ? ovf8  : ovf4;

    serial_addsub #(.WIDTH(4), .DIGIT(1)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a[3:0]), .b(b[3:0]), .sel(sel),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .sel(sel),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result/carry and signed range check.
    function automatic void model(input int w, input int ua, input int ub, input bit op,
                                  output int es, output int ec, output int eo);
        int m, sa, sb, r, sr;
        m  = 1 << w;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (op == OP_SUB) begin
            r  = ua - ub;
            ec = (ua >= ub) ? 1 : 0;
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            ec = (r >= m) ? 1 : 0;
            sr = sa + sb;
        end
        es = ((r % m) + m) % m;
        eo = (sr < -(m / 2) || sr >= m / 2) ? 1 : 0;
    endfunction

    // Called just after a falling edge; returns just after the falling edge of the DONE cycle.
    task automatic do_op(input int ta, input int tb, input bit tsel, input bit mid_pulse);
        int w, n, idx, es, ec, eo, busy_cnt, done_at;
        idx = use8 ? 1 : 0;
        w   = use8 ? 8 : 4;
        n   = use8 ? 2 : 4;
        ta  = ta & ((1 << w) - 1);
        tb  = tb & ((1 << w) - 1);
        model(w, ta, tb, tsel, es, ec, eo);
        a = 8'(ta); b = 8'(tb); sel = tsel; start = 1'b1;
        @(posedge clk);
        busy_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (mid_pulse && i == 2) start = 1'b1;
            if (mid_pulse && i == 3) start = 1'b0;
            if (obusy) busy_cnt++;
            if (odone && done_at == 0) done_at = i;
            if (i == 2) chk("s_hold_run", int'(os), last_s[idx]);
        end
        chk("busy_cycles", busy_cnt, n);
        chk("done_cycle", done_at, n + 1);
        chk("s", int'(os), es);
        chk("cout", int'(ocout), ec);
        chk("ovf", int'(oovf), eo);
        last_s[idx] = es;
        last_c[idx] = ec;
        last_o[idx] = eo;
    endtask

    task automatic idle_check();
        int idx;
        idx = use8 ? 1 : 0;
        @(negedge clk);
        chk("idle_done", int'(odone), 0);
        chk("idle_busy", int'(obusy), 0);
        chk("idle_s_hold", int'(os), last_s[idx]);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_busy"}, int'(obusy), 0);
        chk({tag, "_done"}, int'(odone), 0);
        chk({tag, "_s"}, int'(os), 0);
        chk({tag, "_cout"}, int'(ocout), 0);
        chk({tag, "_ovf"}, int'(oovf), 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            last_s[k] = 0; last_c[k] = 0; last_o[k] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        use8 = 1'b0; #1 reset_check("rst4");
        use8 = 1'b1; #1 reset_check("rst8");
        use8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed 4-bit cases, including the carry/overflow boundaries.
        do_op(5, 1, OP_ADD, 1'b0); idle_check();
        do_op(5, 1, OP_SUB, 1'b0); idle_check();
        do_op(1, 5, OP_SUB, 1'b0); idle_check();
        do_op(0, 0, OP_SUB, 1'b0); idle_check();
        do_op(2, 2, OP_SUB, 1'b0); idle_check();
        do_op(7, 1, OP_ADD, 1'b0); idle_check();
        do_op(8, 1, OP_SUB, 1'b0); idle_check();
        do_op(15, 1, OP_ADD, 1'b0); idle_check();

        // start pulsed mid-RUN must not disturb the op or produce a second done.
        do_op(3, 2, OP_ADD, 1'b1); idle_check();

        // Back-to-back: second start asserted during the DONE cycle.
        do_op(6, 3, OP_ADD, 1'b0);
        do_op(9, 9, OP_SUB, 1'b0);
        idle_check();

        // Asynchronous reset in the second RUN cycle discards the op.
        a = 8'd3; b = 8'd4; sel = OP_ADD; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1 reset_check("rst_mid");
        for (int k = 0; k < 2; k++) begin
            last_s[k] = 0; last_c[k] = 0; last_o[k] = 0;
        end
        @(negedge clk);
        chk("rst_mid_nodone", int'(odone), 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_nodone", int'(odone), 0);
        end
        do_op(2, 2, OP_ADD, 1'b0);
        chk("post_rst_2p2", int'(os), 4);
        idle_check();

        for (int k = 0; k < 25; k++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        // 8-bit, 4-bit digits.
        use8 = 1'b1;
        do_op(8'hFF, 8'h01, OP_ADD, 1'b0); idle_check();
        do_op(8'h80, 8'h01, OP_SUB, 1'b0); idle_check();
        do_op(8'h7F, 8'h01, OP_ADD, 1'b0);
        for (int k = 0; k < 25; k++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
